// File: rtl/md4_block_padder_if.sv
// Byte-in / block-out handshake bundle between the message source, the MD4 padder and the round chain.
interface md4_block_padder_if;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_keep;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_block;
    logic         out_first;
    logic         out_last;

    modport master (
        output in_valid, in_data, in_last, in_keep, out_ready,
        input  in_ready, out_valid, out_block, out_first, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_keep, out_ready,
        output in_ready, out_valid, out_block, out_first, out_last
    );
endinterface

// File: rtl/md4_block_padder.sv
// MD4 message padder: packs bytes into 512-bit blocks, appends 0x80, zero fill and the
// 64-bit little-endian bit length, and flags the first/last block of each message.
module md4_block_padder (
    input  logic              clk,
    input  logic              rst_n,
    md4_block_padder_if.slave bus
);
    typedef enum logic [1:0] {FILL, EMIT, EMIT_PAD} state_t;

    state_t           state_q, state_n;
    logic [63:0][7:0] blk_q, blk_n;
    logic [5:0]       ptr_q, ptr_n;
    logic [63:0]      len_q, len_n;
    logic             first_q, first_n;
    logic [1:0]       pad_q, pad_n;   // 1: next block zero+len, 2: next block 0x80+len
    logic             last_q, last_n;
    logic             in_ready_q, out_valid_q, out_first_q;
    logic             acc;
    logic [6:0]       p;

    assign acc = bus.in_valid && in_ready_q;
    assign p   = {1'b0, ptr_q} + {6'd0, bus.in_keep};

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = blk_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = last_q;

    always_comb begin
        state_n = state_q;
        blk_n   = blk_q;
        ptr_n   = ptr_q;
        len_n   = len_q;
        first_n = first_q;
        pad_n   = pad_q;
        last_n  = last_q;
        case (state_q)
            FILL: begin
                if (acc) begin
                    if (bus.in_keep) begin
                        blk_n[ptr_q] = bus.in_data;
                        ptr_n        = ptr_q + 6'd1;
                        len_n        = len_q + 64'd8;
                    end
                    if (bus.in_last) begin
                        state_n = EMIT;
                        if (p <= 7'd55) begin
                            blk_n[p[5:0]] = 8'h80;
                            for (int i = 0; i < 56; i++)
                                if (i > int'(p)) blk_n[i] = 8'h00;
                            for (int k = 0; k < 8; k++)
                                blk_n[56+k] = len_n[8*k +: 8];
                            last_n = 1'b1;
                        end else if (p <= 7'd63) begin
                            blk_n[p[5:0]] = 8'h80;
                            for (int i = 0; i < 64; i++)
                                if (i > int'(p)) blk_n[i] = 8'h00;
                            pad_n  = 2'd1;
                            last_n = 1'b0;
                        end else begin
                            pad_n  = 2'd2;
                            last_n = 1'b0;
                        end
                    end else if (bus.in_keep && ptr_q == 6'd63) begin
                        state_n = EMIT;
                        last_n  = 1'b0;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    first_n = 1'b0;
                    if (pad_q != 2'd0) begin
                        // Rebuild the buffer as the trailing length block.
                        blk_n = '0;
                        if (pad_q == 2'd2) blk_n[0] = 8'h80;
                        for (int k = 0; k < 8; k++)
                            blk_n[56+k] = len_q[8*k +: 8];
                        pad_n   = 2'd0;
                        last_n  = 1'b1;
                        state_n = EMIT_PAD;
                    end else begin
                        blk_n   = '0;
                        ptr_n   = 6'd0;
                        state_n = FILL;
                        if (last_q) begin
                            len_n   = 64'd0;
                            first_n = 1'b1;
                        end
                        last_n = 1'b0;
                    end
                end
            end
            EMIT_PAD: begin
                if (bus.out_ready) begin
                    blk_n   = '0;
                    ptr_n   = 6'd0;
                    len_n   = 64'd0;
                    first_n = 1'b1;
                    last_n  = 1'b0;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            blk_q       <= '0;
            ptr_q       <= 6'd0;
            len_q       <= 64'd0;
            first_q     <= 1'b1;
            pad_q       <= 2'd0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            blk_q       <= blk_n;
            ptr_q       <= ptr_n;
            len_q       <= len_n;
            first_q     <= first_n;
            pad_q       <= pad_n;
            last_q      <= last_n;
            in_ready_q  <= (state_n == FILL);
            out_valid_q <= (state_n != FILL);
            out_first_q <= (state_n == EMIT) && first_n;
        end
    end
endmodule

// File: tb/tb_md4_block_padder.sv
// Scoreboard bench for md4_block_padder: directed messages push expected blocks, a monitor checks them.
module tb_md4_block_padder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    md4_block_padder_if bus();
    md4_block_padder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [511:0] b, input logic f, input logic l);
        exp_t e;
        e.blk = b; e.first = f; e.last = l;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_block: got %0h expected none", bus.out_block);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_block", bus.out_block, e.blk);
                check("out_first", 512'(bus.out_first), 512'(e.first));
                check("out_last",  512'(bus.out_last),  512'(e.last));
            end
        end
    end

    // All tasks are called at #1 after a rising edge and return at the same phase.
    task automatic send_beat(input logic [7:0] d, input logic l, input logic k);
        int n = 0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l; bus.in_keep = k;
        while (!bus.in_ready && n <= 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n > 200) begin
            tests++; fails++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
        end else begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_keep = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] m[$]);
        for (int i = 0; i < m.size(); i++)
            send_beat(m[i], (i == m.size() - 1), 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_pending", 512'(sb.size()), 512'd0);
    endtask

    function automatic logic [511:0] ramp(input int nbytes);
        logic [511:0] b = '0;
        for (int i = 0; i < nbytes; i++) b[8*i +: 8] = 8'(i);
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] b, abc_blk;
        logic [7:0]   m[$];

        bus.in_valid = 0; bus.in_data = 0; bus.in_last = 0; bus.in_keep = 0; bus.out_ready = 1;
        abc_blk = '0;
        abc_blk[31:0]    = 32'h80636261;
        abc_blk[479:448] = 32'h00000018;

        repeat (2) @(negedge clk);
        check("rst_in_ready",  512'(bus.in_ready),  512'd0);
        check("rst_out_valid", 512'(bus.out_valid), 512'd0);
        check("rst_out_first", 512'(bus.out_first), 512'd0);
        check("rst_out_last",  512'(bus.out_last),  512'd0);
        check("rst_out_block", bus.out_block, 512'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", 512'(bus.in_ready), 512'd1);

        // Empty message
        b = '0; b[31:0] = 32'h00000080;
        push(b, 1'b1, 1'b1);
        send_beat(8'h00, 1'b1, 1'b0);
        drain();

        // "abc" with latency check
        push(abc_blk, 1'b1, 1'b1);
        send_beat(8'h61, 1'b0, 1'b1);
        send_beat(8'h62, 1'b0, 1'b1);
        check("abc_valid_before_last", 512'(bus.out_valid), 512'd0);
        send_beat(8'h63, 1'b1, 1'b1);
        check("abc_valid_after_last", 512'(bus.out_valid), 512'd1);
        drain();

        // 55 bytes: single block
        b = ramp(55); b[8*55 +: 8] = 8'h80; b[479:448] = 32'h000001B8;
        push(b, 1'b1, 1'b1);
        m = {}; for (int i = 0; i < 55; i++) m.push_back(8'(i));
        send_msg(m);
        drain();

        // 56 bytes: marker fills block 1, length in block 2
        b = ramp(56); b[8*56 +: 8] = 8'h80;
        push(b, 1'b1, 1'b0);
        b = '0; b[479:448] = 32'h000001C0;
        push(b, 1'b0, 1'b1);
        m = {}; for (int i = 0; i < 56; i++) m.push_back(8'(i));
        send_msg(m);
        drain();

        // 64 bytes: no bubble before the pad block, then a fresh message
        push(ramp(64), 1'b1, 1'b0);
        b = '0; b[31:0] = 32'h00000080; b[479:448] = 32'h00000200;
        push(b, 1'b0, 1'b1);
        m = {}; for (int i = 0; i < 64; i++) m.push_back(8'(i));
        send_msg(m);
        check("b64_blk1_valid", 512'(bus.out_valid), 512'd1);
        check("b64_blk1_last",  512'(bus.out_last),  512'd0);
        @(posedge clk); #1;
        check("b64_blk2_valid_no_bubble", 512'(bus.out_valid), 512'd1);
        check("b64_blk2_last",            512'(bus.out_last),  512'd1);
        push(abc_blk, 1'b1, 1'b1);
        send_msg('{8'h61, 8'h62, 8'h63});
        drain();

        // Backpressure: block and in_ready hold while out_ready is low
        bus.out_ready = 1'b0;
        push(abc_blk, 1'b1, 1'b1);
        send_msg('{8'h61, 8'h62, 8'h63});
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_out_valid", 512'(bus.out_valid), 512'd1);
            check("stall_in_ready",  512'(bus.in_ready),  512'd0);
            check("stall_out_block", bus.out_block, abc_blk);
        end
        bus.out_ready = 1'b1;
        drain();

        // Reset while a block is presented
        bus.out_ready = 1'b0;
        send_msg('{8'h78, 8'h79, 8'h7a});
        check("pre_rst_out_valid", 512'(bus.out_valid), 512'd1);
        rst_n = 1'b0; #1;
        check("rst_emit_out_valid", 512'(bus.out_valid), 512'd0);
        check("rst_emit_in_ready",  512'(bus.in_ready),  512'd0);
        @(posedge clk); #1 rst_n = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset mid-message, then an ignored keep=0 beat, then "abc"
        for (int i = 0; i < 5; i++) send_beat(8'(8'hA0 + i), 1'b0, 1'b1);
        rst_n = 1'b0; #1;
        check("rst_mid_out_valid", 512'(bus.out_valid), 512'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_beat(8'hFF, 1'b0, 1'b0);
        push(abc_blk, 1'b1, 1'b1);
        send_msg('{8'h61, 8'h62, 8'h63});
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
